// File: rtl/gray_conv_pkg.sv
// gray_conv_pkg
// Shared definitions for the Gray code conversion arbiter.
// - MODE_B2G / MODE_G2B: values of the per-request direction bit.
// - bin2gray / gray2bin: reference conversions on a MAX_W-bit word.
//   Callers zero-extend narrower values and then truncate the result.
//   Zero upper bits do not change the low bits of either conversion, so
//   the same functions serve every WIDTH up to MAX_W.
package gray_conv_pkg;

  localparam int   MAX_W    = 32;
  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;

  typedef logic [MAX_W-1:0] conv_word_t;

  // Binary to Gray: each Gray bit is the XOR of two adjacent binary bits.
  function automatic conv_word_t bin2gray(input conv_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: a running XOR from the MSB downwards.
  function automatic conv_word_t gray2bin(input conv_word_t g);
    conv_word_t b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int k = MAX_W - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_conv_core.sv
// gray_conv_core
// Purely combinational binary/Gray converter.
// Ports:
//   din_i   WIDTH  value to convert
//   mode_i  1      0 = binary->Gray, 1 = Gray->binary
//   dout_o  WIDTH  converted value
module gray_conv_core
  import gray_conv_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] din_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] dout_o
);

  conv_word_t din_ext;

  // Widen to the package word, convert in the chosen direction and keep
  // only the low WIDTH bits.
  always_comb begin
    din_ext = MAX_W'(din_i);
    if (mode_i == MODE_G2B) begin
      dout_o = WIDTH'(gray2bin(din_ext));
    end else begin
      dout_o = WIDTH'(bin2gray(din_ext));
    end
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter
// Round-robin arbitration of NREQ requesters onto one shared converter.
// The result goes into a one-stage output register.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   req_valid_i   NREQ        per-requester request valid
//   req_ready_o   NREQ        per-requester accept (one-hot or zero)
//   req_data_i    NREQ*WIDTH  requester i at [i*WIDTH +: WIDTH]
//   req_mode_i    NREQ        per-requester direction (0 = B2G, 1 = G2B)
//   out_valid_o   1           output register holds a result
//   out_ready_i   1           downstream accepts the result
//   out_data_o    WIDTH       converted value
//   out_id_o      IDW         requester that produced out_data_o
//   out_mode_o    1           direction used for out_data_o
module gray_conv_arbiter
  import gray_conv_pkg::*;
#(
  parameter  int WIDTH = 3,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*WIDTH-1:0] req_data_i,
  input  logic [NREQ-1:0]       req_mode_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [WIDTH-1:0]      out_data_o,
  output logic [IDW-1:0]        out_id_o,
  output logic                  out_mode_o
);

  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [IDW-1:0]   out_id_q, out_id_d;
  logic             out_mode_q, out_mode_d;

  logic             load;
  logic             found;
  logic             grant;
  logic [IDW-1:0]   cand;
  logic [IDW-1:0]   winner;
  logic [WIDTH-1:0] sel_data;
  logic             sel_mode;
  logic [WIDTH-1:0] conv_data;

  // The output register can take a new result when it is empty or
  // when it is being drained this cycle.
  assign load  = !out_valid_q || out_ready_i;
  assign grant = found && load && !rst;

  // Scan from the requester after the last winner and wrap around.
  // The first requester with valid set wins.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = IDW'((int'(rr_ptr_q) + off) % NREQ);
      if (!found && req_valid_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Select the winner's data and mode for the shared converter.
  always_comb begin
    sel_data = '0;
    sel_mode = MODE_B2G;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) begin
        sel_data = req_data_i[i*WIDTH +: WIDTH];
        sel_mode = req_mode_i[i];
      end
    end
  end

  // Only the winner sees ready, and only when the output can load.
  always_comb begin
    req_ready_o = '0;
    if (grant) begin
      req_ready_o[winner] = 1'b1;
    end
  end

  gray_conv_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .din_i  (sel_data),
    .mode_i (sel_mode),
    .dout_o (conv_data)
  );

  // Next state: capture on a grant, drain when accepted with nothing new,
  // and otherwise hold. The pointer moves only on an accepted transfer.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_mode_d  = out_mode_q;
    if (grant) begin
      rr_ptr_d    = winner;
      out_valid_d = 1'b1;
      out_data_d  = conv_data;
      out_id_d    = winner;
      out_mode_d  = sel_mode;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers. On reset the pointer is set to the last requester,
  // so requester 0 is scanned first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= IDW'(NREQ - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_mode_q  <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_mode_q  <= out_mode_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_id_o    = out_id_q;
  assign out_mode_o  = out_mode_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb_gray_conv_arbiter
// Self-checking bench for gray_conv_arbiter with WIDTH=3 and NREQ=4.
// A cycle model predicts req_ready and transfers. Predicted results go
// into a scoreboard queue and are compared while they sit in the output
// register. A constant table gives the conversion values independently of
// the package functions.
module tb_gray_conv_arbiter;
  import gray_conv_pkg::*;

  localparam int WIDTH = 3;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [IDW-1:0]        out_id;
  logic                  out_mode;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [IDW-1:0]   id;
    logic             mode;
  } sb_entry_t;

  typedef struct {
    logic [IDW-1:0]   reqId;
    logic [WIDTH-1:0] din;
    logic             mode;
    logic [WIDTH-1:0] expOut;
  } conv_vec_t;

  sb_entry_t sbQueue[$];
  conv_vec_t vecTable[17];
  int        vectorCount;
  int        missCount;
  int        modelPtr;
  logic      modelValid;

  gray_conv_arbiter #(
    .WIDTH (WIDTH),
    .NREQ  (NREQ)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_data_i  (req_data),
    .req_mode_i  (req_mode),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_id_o    (out_id),
    .out_mode_o  (out_mode)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record one comparison and report it if it differs.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference conversion built on the package functions.
  function automatic logic [WIDTH-1:0] modelConv(input logic [WIDTH-1:0] d,
                                                 input logic m);
    conv_word_t w;
    if (m == MODE_G2B) w = gray2bin(conv_word_t'(d));
    else               w = bin2gray(conv_word_t'(d));
    return w[WIDTH-1:0];
  endfunction

  // Round-robin winner as seen from the model pointer, or -1 if idle.
  function automatic int modelWinner(input logic [NREQ-1:0] v, input int ptr);
    for (int off = 1; off <= NREQ; off++) begin
      int idx;
      idx = (ptr + off) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic applyStimulus(input logic [NREQ-1:0] v,
                               input logic [NREQ*WIDTH-1:0] d,
                               input logic [NREQ-1:0] m, input logic r);
    req_valid = v;
    req_data  = d;
    req_mode  = m;
    out_ready = r;
  endtask

  // Clear the model and the scoreboard to match a reset DUT.
  task automatic resetModel();
    modelValid = 1'b0;
    modelPtr   = NREQ - 1;
    sbQueue.delete();
  endtask

  task automatic applyReset();
    rst = 1'b1;
    applyStimulus('0, '0, '0, 1'b1);
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Run one clock. At the falling edge, compare against the model and the
  // scoreboard head, then advance the model. Return 1 unit after the rising edge.
  task automatic runCycle();
    int              w;
    logic [NREQ-1:0] expReady;
    sb_entry_t       e;
    @(negedge clk);
    w        = modelWinner(req_valid, modelPtr);
    expReady = '0;
    if (!rst && w >= 0 && (!modelValid || out_ready)) expReady[w] = 1'b1;
    checkOutput("req_ready", 32'(req_ready), 32'(expReady));
    checkOutput("out_valid", 32'(out_valid), 32'(modelValid));
    if (modelValid && sbQueue.size() > 0) begin
      checkOutput("sb_data", 32'(out_data), 32'(sbQueue[0].data));
      checkOutput("sb_id",   32'(out_id),   32'(sbQueue[0].id));
      checkOutput("sb_mode", 32'(out_mode), 32'(sbQueue[0].mode));
    end
    if (modelValid && out_ready && sbQueue.size() > 0) begin
      void'(sbQueue.pop_front());
    end
    if (expReady != '0) begin
      e.data = modelConv(req_data[w*WIDTH +: WIDTH], req_mode[w]);
      e.id   = IDW'(w);
      e.mode = req_mode[w];
      sbQueue.push_back(e);
      modelValid = 1'b1;
      modelPtr   = w;
    end else if (out_ready) begin
      modelValid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0]            grayList[8];
    logic [NREQ*WIDTH-1:0] dataWord;
    logic [NREQ-1:0]       modeWord;
    logic [NREQ-1:0]       expOneHot;

    vectorCount = 0;
    missCount   = 0;
    grayList = '{3'b000, 3'b001, 3'b011, 3'b010,
                 3'b110, 3'b111, 3'b101, 3'b100};

    // Requester 0 does B2G over 0..7. Requester 2 does 111->101 and then
    // G2B over the Gray sequence, which must give 0..7 back.
    for (int i = 0; i < 8; i++) begin
      vecTable[i] = '{reqId: 2'd0, din: 3'(i), mode: MODE_B2G, expOut: grayList[i]};
    end
    vecTable[8] = '{reqId: 2'd2, din: 3'b111, mode: MODE_G2B, expOut: 3'b101};
    for (int i = 0; i < 8; i++) begin
      vecTable[9+i] = '{reqId: 2'd2, din: grayList[i], mode: MODE_G2B, expOut: 3'(i)};
    end

    // Reset values with no requests, then idle cycles after release.
    rst = 1'b1;
    applyStimulus('0, '0, '0, 1'b1);
    resetModel();
    #2;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data",  32'(out_data),  32'd0);
    checkOutput("rst_out_id",    32'(out_id),    32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    applyReset();
    repeat (2) runCycle();

    // Single-requester conversion sweeps, back to back.
    foreach (vecTable[i]) begin
      dataWord = '0;
      modeWord = '0;
      dataWord[vecTable[i].reqId*WIDTH +: WIDTH] = vecTable[i].din;
      modeWord[vecTable[i].reqId] = vecTable[i].mode;
      applyStimulus(NREQ'(1) << vecTable[i].reqId, dataWord, modeWord, 1'b1);
      runCycle();
      checkOutput("tbl_data", 32'(out_data), 32'(vecTable[i].expOut));
      checkOutput("tbl_id",   32'(out_id),   32'(vecTable[i].reqId));
      checkOutput("tbl_mode", 32'(out_mode), 32'(vecTable[i].mode));
    end
    applyStimulus('0, '0, '0, 1'b1);
    repeat (2) runCycle();

    // All requesters valid: grants rotate 0,1,2,3 twice.
    applyReset();
    dataWord = NREQ*WIDTH'($urandom);
    modeWord = NREQ'($urandom);
    applyStimulus('1, dataWord, modeWord, 1'b1);
    for (int i = 0; i < 8; i++) begin
      #1;
      expOneHot = NREQ'(1) << (i % NREQ);
      checkOutput("rr_ready", 32'(req_ready), 32'(expOneHot));
      runCycle();
      checkOutput("rr_id", 32'(out_id), 32'(i % NREQ));
    end

    // Backpressure after a grant to requester 1: output holds and nothing
    // is granted. The grant after release goes to requester 2.
    runCycle();
    runCycle();
    checkOutput("bp_grant_id", 32'(out_id), 32'd1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      runCycle();
      checkOutput("bp_hold_id",    32'(out_id),    32'd1);
      checkOutput("bp_hold_ready", 32'(req_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", 32'(req_ready), 32'b0100);
    runCycle();
    checkOutput("bp_release_id", 32'(out_id), 32'd2);

    // Assert reset mid-cycle while a result is held. It must clear at once.
    applyStimulus(4'b1010, dataWord, modeWord, 1'b1);
    runCycle();
    checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    resetModel();
    #1;
    checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("async_rst_data",  32'(out_data),  32'd0);
    checkOutput("async_rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = '1;
    #1;
    checkOutput("post_rst_ready", 32'(req_ready), 32'b0001);
    runCycle();
    checkOutput("post_rst_id", 32'(out_id), 32'd0);
    runCycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
